// File: rtl/deco_prioridad_reg.sv
// Registered select-code decoder with a minimum output hold time.
// Latency: code accepted at edge k, salida/salida_valid updated at edge k+1.
// Backpressure: sel_ready high only in IDLE with borrar low; codes offered outside IDLE are dropped, never queued.
//
// Ports:
//   clk, rst_n          single rising-edge clock, async active-low reset
//   sel_i/sel_valid/sel_ready  select-code handshake
//   borrar              synchronous clear of salida and the FSM (wins over everything)
//   salida              registered decoded output (N_CH bits)
//   salida_valid        one-cycle pulse when salida updates
//   fuera_rango         one-cycle pulse alongside salida_valid for an out-of-range code
//   ocupado             high whenever the FSM is not in IDLE
// Build option: define DECO_PRIORIDAD_TERMO_EN for thermometer output instead of one-hot.
module deco_prioridad_reg #(
    parameter int SEL_W    = 4,
    parameter int N_CH     = 8,
    parameter int BASE     = 3,
    parameter int HOLD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic             borrar,
    output logic [N_CH-1:0]  salida,
    output logic             salida_valid,
    output logic             fuera_rango,
    output logic             ocupado
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0]     HOLD_LD = 8'(HOLD_CYC - 1);
    localparam logic [SEL_W:0] BASE_X  = (SEL_W+1)'(BASE);
    localparam logic [SEL_W:0] NCH_X   = (SEL_W+1)'(N_CH);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [N_CH-1:0]   salida_q, salida_d;
    logic              vld_q, vld_d;
    logic              fr_q, fr_d;

    // Offset computed one bit wider than the code so that codes below BASE
    // land at the top of the range and fail the in-range test instead of
    // wrapping into a valid channel.
    logic [SEL_W:0]    off;
    logic              in_rng;
    logic [N_CH-1:0]   dec_val;

    always_comb begin
        off     = {1'b0, sel_q} - BASE_X;
        in_rng  = (off < NCH_X);
        dec_val = '0;
        for (int i = 0; i < N_CH; i++) begin
`ifdef DECO_PRIORIDAD_TERMO_EN
            dec_val[i] = in_rng && (off >= (SEL_W+1)'(i));
`else
            dec_val[i] = in_rng && (off == (SEL_W+1)'(i));
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        salida_d = salida_q;
        vld_d    = 1'b0;
        fr_d     = 1'b0;
        if (borrar) begin
            // Clear dominates both a pending handshake and a DECODE completion.
            state_d  = IDLE;
            cnt_d    = '0;
            salida_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        sel_d   = sel_i;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    salida_d = dec_val;
                    vld_d    = 1'b1;
                    fr_d     = ~in_rng;
                    cnt_d    = HOLD_LD;
                    state_d  = HOLD;
                end
                HOLD: begin
                    // Counter loaded with HOLD_CYC-1; leaving on the zero edge
                    // gives exactly HOLD_CYC cycles in this state.
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            salida_q <= '0;
            vld_q    <= 1'b0;
            fr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            salida_q <= salida_d;
            vld_q    <= vld_d;
            fr_q     <= fr_d;
        end
    end

    // rst_n gates ready so no handshake is advertised while reset is held.
    assign sel_ready    = rst_n && (state_q == IDLE) && !borrar;
    assign ocupado      = (state_q != IDLE);
    assign salida       = salida_q;
    assign salida_valid = vld_q;
    assign fuera_rango  = fr_q;

endmodule

// File: tb/tb_deco_prioridad_reg.sv
module tb_deco_prioridad_reg;

    localparam int SEL_W    = 4;
    localparam int N_CH     = 8;
    localparam int BASE     = 3;
    localparam int HOLD_CYC = 4;

    logic             clk;
    logic             rst_n;
    logic [SEL_W-1:0] sel_i;
    logic             sel_valid;
    logic             sel_ready;
    logic             borrar;
    logic [N_CH-1:0]  salida;
    logic             salida_valid;
    logic             fuera_rango;
    logic             ocupado;

    int checks = 0;
    int errors = 0;
    logic [N_CH-1:0] exp_sal;

    deco_prioridad_reg #(
        .SEL_W(SEL_W), .N_CH(N_CH), .BASE(BASE), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel_i(sel_i), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .borrar(borrar), .salida(salida),
        .salida_valid(salida_valid), .fuera_rango(fuera_rango), .ocupado(ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: in-range codes select channel (s-BASE); out-of-range gives zero.
    function automatic logic [N_CH-1:0] ref_dec(input int s);
        if (s < BASE || s >= BASE + N_CH) return '0;
`ifdef DECO_PRIORIDAD_TERMO_EN
        return N_CH'((1 << (s - BASE + 1)) - 1);
`else
        return N_CH'(1 << (s - BASE));
`endif
    endfunction

    function automatic logic ref_out(input int s);
        return (s < BASE || s >= BASE + N_CH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sel_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 32'(sel_ready), 32'd1);
    endtask

    // Full transaction starting at a negedge while IDLE. Optional noise on
    // sel_valid/sel_i during HOLD must be ignored.
    task automatic do_txn(input int s, input bit noise);
        sel_i     = SEL_W'(s);
        sel_valid = 1'b1;
        @(negedge clk);                       // edge k passed
        check("decode_ready", 32'(sel_ready), 32'd0);
        check("decode_busy", 32'(ocupado), 32'd1);
        check("decode_novld", 32'(salida_valid), 32'd0);
        check("decode_hold_sal", 32'(salida), 32'(exp_sal));
        sel_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sel_i     = SEL_W'($urandom_range(0, 15));
        @(negedge clk);                       // edge k+1 passed
        exp_sal = ref_dec(s);
        check("upd_salida", 32'(salida), 32'(exp_sal));
        check("upd_valid", 32'(salida_valid), 32'd1);
        check("upd_fuera", 32'(fuera_rango), 32'(ref_out(s)));
        check("upd_ready", 32'(sel_ready), 32'd0);
        for (int n = 2; n <= HOLD_CYC + 1; n++) begin
            if (n < HOLD_CYC + 1) begin
                sel_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                sel_i     = SEL_W'($urandom_range(0, 15));
            end else begin
                sel_valid = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", 32'(salida_valid), 32'd0);
            check("hold_fuera", 32'(fuera_rango), 32'd0);
            check("hold_salida", 32'(salida), 32'(exp_sal));
            check("hold_ready", 32'(sel_ready), 32'(n == HOLD_CYC + 1));
            check("hold_busy", 32'(ocupado), 32'(n != HOLD_CYC + 1));
        end
        sel_valid = 1'b0;
    endtask

    initial begin
        int c1, c2;
        logic [N_CH-1:0] sal2;

        rst_n = 1'b0; sel_i = '0; sel_valid = 1'b0; borrar = 1'b0;
        exp_sal = '0;
        #2;
        sel_valid = 1'b1;
        @(negedge clk);
        check("rst_salida", 32'(salida), 32'd0);
        check("rst_valid", 32'(salida_valid), 32'd0);
        check("rst_fuera", 32'(fuera_rango), 32'd0);
        check("rst_busy", 32'(ocupado), 32'd0);
        check("rst_ready", 32'(sel_ready), 32'd0);
        sel_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(sel_ready), 32'd1);

        // Directed codes including the range boundaries.
        do_txn(5, 1'b0);
        do_txn(3, 1'b0);
        do_txn(10, 1'b0);
        do_txn(2, 1'b0);
        do_txn(11, 1'b0);
        do_txn(6, 1'b0);
        do_txn(0, 1'b0);
        do_txn(15, 1'b0);

        // sel_valid held high through HOLD: second update HOLD_CYC+2 cycles later.
        c1 = -1; c2 = -1; sal2 = '0;
        sel_i = SEL_W'(7); sel_valid = 1'b1;
        for (int i = 0; i < 40 && c2 < 0; i++) begin
            @(negedge clk);
            if (salida_valid === 1'b1) begin
                if (c1 < 0) c1 = i;
                else begin
                    c2 = i;
                    sal2 = salida;
                end
            end
        end
        sel_valid = 1'b0;
        check("held_gap", 32'(c2 - c1), 32'(HOLD_CYC + 2));
        check("held_salida", 32'(sal2), 32'(ref_dec(7)));
        exp_sal = ref_dec(7);
        wait_idle();

        // borrar together with a handshake.
        sel_i = SEL_W'(5); sel_valid = 1'b1; borrar = 1'b1;
        #1;
        check("clr_hs_ready", 32'(sel_ready), 32'd0);
        @(negedge clk);
        sel_valid = 1'b0; borrar = 1'b0;
        exp_sal = '0;
        check("clr_hs_salida", 32'(salida), 32'd0);
        check("clr_hs_busy", 32'(ocupado), 32'd0);
        check("clr_hs_valid", 32'(salida_valid), 32'd0);
        @(negedge clk);
        check("clr_hs_valid2", 32'(salida_valid), 32'd0);
        check("clr_hs_busy2", 32'(ocupado), 32'd0);

        // borrar during DECODE discards the update (out-of-range code, so no fuera_rango either).
        do_txn(8, 1'b0);
        sel_i = SEL_W'(11); sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0; borrar = 1'b1;
        @(negedge clk);
        borrar = 1'b0;
        exp_sal = '0;
        check("clr_dec_salida", 32'(salida), 32'd0);
        check("clr_dec_valid", 32'(salida_valid), 32'd0);
        check("clr_dec_fuera", 32'(fuera_rango), 32'd0);
        check("clr_dec_busy", 32'(ocupado), 32'd0);
        @(negedge clk);
        check("clr_dec_valid2", 32'(salida_valid), 32'd0);
        check("clr_dec_fuera2", 32'(fuera_rango), 32'd0);
        check("clr_dec_ready", 32'(sel_ready), 32'd1);

        // Async reset mid-HOLD, between edges.
        sel_i = SEL_W'(5); sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_sal = '0;
        check("arst_salida", 32'(salida), 32'd0);
        check("arst_busy", 32'(ocupado), 32'd0);
        check("arst_valid", 32'(salida_valid), 32'd0);
        check("arst_ready", 32'(sel_ready), 32'd0);
        @(negedge clk);
        check("arst_salida2", 32'(salida), 32'd0);
        rst_n = 1'b1;
        do_txn(9, 1'b0);

        // Randomized codes with handshake noise during HOLD.
        for (int r = 0; r < 20; r++) begin
            do_txn(int'($urandom_range(0, 15)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
